// File: rtl/leds.sv
// Board LED driver: prescaled step tick animates a 4-bit pattern onto D1..D4.
// Optional PWM dimming is enabled by defining LEDS_PWM_EN.
module leds #(
  parameter logic [3:0] PATTERN = 4'b1010,
  parameter int         MODE    = 0,
  parameter int         DIV     = 12000000,
  parameter int         DUTY    = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4
);

  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_MAX = CW'(DIV - 1);
  localparam logic [3:0]     PAT_RST = (MODE == 2) ? 4'b0001 : PATTERN;

  typedef enum logic { DIR_UP, DIR_DN } dir_e;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    led_q, led_d;
  dir_e          dir_q, dir_d;
  logic          tick;

  assign tick = (div_cnt_q == DIV_MAX);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    pat_d     = pat_q;
    dir_d     = dir_q;
    if (tick) begin
      case (MODE)
        1: pat_d = pat_q + 4'd1;
        2: begin
          // the turn-around and the first step back happen on the same tick
          if (dir_q == DIR_UP) begin
            if (pat_q == 4'b1000) begin
              dir_d = DIR_DN;
              pat_d = 4'b0100;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q == 4'b0001) begin
              dir_d = DIR_UP;
              pat_d = 4'b0010;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        3: pat_d = (pat_q == PATTERN) ? 4'b0000 : PATTERN;
        default: pat_d = pat_q;
      endcase
    end
  end

`ifdef LEDS_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on;
  localparam logic [3:0] LED_RST = PAT_RST & {4{DUTY > 0}};

  assign pwm_on = ({1'b0, pwm_cnt_q} < 5'(DUTY));

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    led_d     = pat_q & {4{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end
`else
  localparam logic [3:0] LED_RST = PAT_RST;

  always_comb begin
    led_d = pat_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pat_q     <= PAT_RST;
      dir_q     <= DIR_UP;
      led_q     <= LED_RST;
    end else begin
      div_cnt_q <= div_cnt_d;
      pat_q     <= pat_d;
      dir_q     <= dir_d;
      led_q     <= led_d;
    end
  end

  assign D1 = led_q[0];
  assign D2 = led_q[1];
  assign D3 = led_q[2];
  assign D4 = led_q[3];

endmodule

// File: tb/tb_leds.sv
// Directed bench for leds: one instance per animation mode, sampled 1ns after each edge.
module tb_leds;

  logic clk = 1'b0;
  logic rst_n, rst1_n;
  always #5 clk = ~clk;

`ifdef LEDS_PWM_EN
  localparam int FULL = 16;
`else
  localparam int FULL = 8;
`endif

  logic [3:0] d0, d1, d2, d3, d4;

  leds #(.PATTERN(4'b1010), .MODE(0), .DIV(3), .DUTY(FULL)) u_m0 (
    .clk(clk), .rst_n(rst_n), .D1(d0[0]), .D2(d0[1]), .D3(d0[2]), .D4(d0[3]));
  leds #(.PATTERN(4'b1110), .MODE(1), .DIV(1), .DUTY(FULL)) u_m1 (
    .clk(clk), .rst_n(rst1_n), .D1(d1[0]), .D2(d1[1]), .D3(d1[2]), .D4(d1[3]));
  leds #(.PATTERN(4'b1010), .MODE(2), .DIV(2), .DUTY(FULL)) u_m2 (
    .clk(clk), .rst_n(rst_n), .D1(d2[0]), .D2(d2[1]), .D3(d2[2]), .D4(d2[3]));
  leds #(.PATTERN(4'b1010), .MODE(3), .DIV(4), .DUTY(FULL)) u_m3 (
    .clk(clk), .rst_n(rst_n), .D1(d3[0]), .D2(d3[1]), .D3(d3[2]), .D4(d3[3]));
  leds #(.PATTERN(4'b0110), .MODE(5), .DIV(1), .DUTY(FULL)) u_bad (
    .clk(clk), .rst_n(rst_n), .D1(d4[0]), .D2(d4[1]), .D3(d4[2]), .D4(d4[3]));

`ifdef LEDS_PWM_EN
  logic [3:0] dp4, dp0;
  leds #(.PATTERN(4'b1010), .MODE(0), .DIV(1), .DUTY(4)) u_pwm4 (
    .clk(clk), .rst_n(rst_n), .D1(dp4[0]), .D2(dp4[1]), .D3(dp4[2]), .D4(dp4[3]));
  leds #(.PATTERN(4'b1010), .MODE(0), .DIV(1), .DUTY(0)) u_pwm0 (
    .clk(clk), .rst_n(rst_n), .D1(dp0[0]), .D2(dp0[1]), .D3(dp0[2]), .D4(dp0[3]));
  int on_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[3:0], exp[3:0]);
    end
  endtask

  // expected D4..D1 after edge k (k = 1..16) following reset release
  logic [3:0] exp1 [1:16] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                              4'b1110, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
  logic [3:0] exp2 [1:16] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                              4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
  logic [3:0] exp3 [1:16] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_m0", {28'd0, d0}, 32'b1010);
    chk("rst_m1", {28'd0, d1}, 32'b1110);
    chk("rst_m2", {28'd0, d2}, 32'b0001);
    chk("rst_m3", {28'd0, d3}, 32'b1010);
    chk("rst_bad", {28'd0, d4}, 32'b0110);
`ifdef LEDS_PWM_EN
    chk("rst_pwm4", {28'd0, dp4}, 32'b1010);
    chk("rst_pwm0", {28'd0, dp0}, 32'b0000);
`endif
    @(posedge clk); #1;
    chk("rst2_m0", {28'd0, d0}, 32'b1010);
    chk("rst2_m1", {28'd0, d1}, 32'b1110);
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      chk("m0_static", {28'd0, d0}, 32'b1010);
      chk("bad_mode", {28'd0, d4}, 32'b0110);
      if (k <= 16) begin
        chk($sformatf("m1_k%0d", k), {28'd0, d1}, {28'd0, exp1[k]});
        chk($sformatf("m2_k%0d", k), {28'd0, d2}, {28'd0, exp2[k]});
        chk($sformatf("m3_k%0d", k), {28'd0, d3}, {28'd0, exp3[k]});
`ifdef LEDS_PWM_EN
        chk($sformatf("pwm0_k%0d", k), {28'd0, dp0}, 32'b0000);
        chk($sformatf("pwm4_d1_k%0d", k), {31'd0, dp4[0]}, 32'd0);
        if (dp4[1]) on_cnt++;
`endif
      end
      // mid-run reset of the counter instance while it shows 0101
      if (k == 8) rst1_n = 1'b0;
      if (k == 9) rst1_n = 1'b1;
    end
`ifdef LEDS_PWM_EN
    chk("pwm4_on_cycles", on_cnt, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
